gate_sweep_ctrl: RTL and testbench

Sequencer that sweeps every input vector of a small combinational gate-under-test, such as my_or. It drives one vector at a time and waits a programmable settle time. It then samples the gate output and compares it against a latched expected truth table. It reports the mismatch count and the first failing vector, so gate checks run in clocked hardware or at system level instead of only in hand-written benches.

---
 rtl/gate_sweep_pkg.sv | 14 +
 rtl/gate_sweep_ctrl_settle_timer.sv | 33 +++
 rtl/gate_sweep_ctrl.sv | 151 +++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } sweep_state_t;

    function automatic int num_vectors(input int n_in);
        return 32'sd1 <<< n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Per-vector settle counter: expire is high in the last cycle a vector is held,
// and the counter wraps to zero on that edge so the next vector starts fresh.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    assign expire = (cnt_r == LAST_CNT);

    // Settle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear || (enable && expire)) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all input vectors of a small combinational gate, compares each sampled
// output against a latched truth table and reports mismatch count / first failure.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   truth,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic                   first_fail_valid
);

    localparam int NV = num_vectors(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    sweep_state_t      state_r, state_nxt_s;
    logic [NV-1:0]     truth_q_r, truth_nxt_s;
    logic [N_IN-1:0]   vec_r, vec_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              pass_r, pass_nxt_s;
    logic [N_IN:0]     err_count_r, err_nxt_s, err_inc_s;
    logic [N_IN-1:0]   ffi_r, ffi_nxt_s;
    logic              ffv_r, ffv_nxt_s;
    logic              mismatch_s;
    logic              timer_clear_s, timer_en_s, timer_expire_s;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .expire (timer_expire_s)
    );

    // Next-state and next-result computation for the sweep sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        truth_nxt_s   = truth_q_r;
        vec_nxt_s     = vec_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        pass_nxt_s    = pass_r;
        err_nxt_s     = err_count_r;
        ffi_nxt_s     = ffi_r;
        ffv_nxt_s     = ffv_r;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        mismatch_s    = (dut_out != truth_q_r[vec_r]);
        err_inc_s     = err_count_r + {{N_IN{1'b0}}, mismatch_s};

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s   = ST_SETTLE;
                    truth_nxt_s   = truth;
                    vec_nxt_s     = {N_IN{1'b0}};
                    busy_nxt_s    = 1'b1;
                    pass_nxt_s    = 1'b0;
                    err_nxt_s     = {(N_IN+1){1'b0}};
                    ffi_nxt_s     = {N_IN{1'b0}};
                    ffv_nxt_s     = 1'b0;
                    timer_clear_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                timer_en_s = 1'b1;
                if (timer_expire_s) begin
                    err_nxt_s = err_inc_s;
                    if (mismatch_s && !ffv_r) begin
                        ffi_nxt_s = vec_r;
                        ffv_nxt_s = 1'b1;
                    end else begin
                        ffi_nxt_s = ffi_r;
                        ffv_nxt_s = ffv_r;
                    end
                    // The final sample must be folded into pass, hence err_inc_s.
                    if (vec_r == LAST_VEC) begin
                        state_nxt_s = ST_DONE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_inc_s == {(N_IN+1){1'b0}});
                    end else begin
                        vec_nxt_s = vec_r + N_IN'(1'b1);
                    end
                end else begin
                    err_nxt_s = err_count_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Vector, latched truth table and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            truth_q_r   <= {NV{1'b0}};
            vec_r       <= {N_IN{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= {(N_IN+1){1'b0}};
            ffi_r       <= {N_IN{1'b0}};
            ffv_r       <= 1'b0;
        end else begin
            truth_q_r   <= truth_nxt_s;
            vec_r       <= vec_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            pass_r      <= pass_nxt_s;
            err_count_r <= err_nxt_s;
            ffi_r       <= ffi_nxt_s;
            ffv_r       <= ffv_nxt_s;
        end
    end

    assign dut_in           = vec_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_count_r;
    assign first_fail_idx   = ffi_r;
    assign first_fail_valid = ffv_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: directed and randomized sweeps against
// an expected-result model computed from the gate function and truth table.
module tb_gate_sweep_ctrl;

    localparam int NV_A = 4;
    localparam int SC_A = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start_a = 1'b0;
    logic [3:0] truth_a = 4'b0000;
    logic [1:0] dut_in_a;
    logic       dut_out_a;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic [2:0] err_a;
    logic [1:0] ffi_a;

    logic       start_b = 1'b0;
    logic [3:0] truth_b = 4'b0000;
    logic [1:0] dut_in_b;
    logic       dut_out_b;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [2:0] err_b;
    logic [1:0] ffi_b;

    int         mode_a = 0;
    logic [3:0] tbl_a  = 4'b0000;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .truth(truth_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_fail_idx(ffi_a),
        .first_fail_valid(ffv_a)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .truth(truth_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_fail_idx(ffi_b),
        .first_fail_valid(ffv_b)
    );

    // Gate models: 0 OR, 1 AND, 2 stuck-0, 3 stuck-1, otherwise lookup table.
    function automatic logic gate_val(input int mode, input int v, input logic [3:0] tbl);
        case (mode)
            0:       return (v != 0);
            1:       return (v == 3);
            2:       return 1'b0;
            3:       return 1'b1;
            default: return tbl[v];
        endcase
    endfunction

    always_comb dut_out_a = gate_val(mode_a, int'(dut_in_a), tbl_a);
    always_comb dut_out_b = |dut_in_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".dut_in"}, 32'(dut_in_a), 0);
        chk({tag, ".busy"}, 32'(busy_a), 0);
        chk({tag, ".done"}, 32'(done_a), 0);
        chk({tag, ".pass"}, 32'(pass_a), 0);
        chk({tag, ".err"}, 32'(err_a), 0);
        chk({tag, ".ffi"}, 32'(ffi_a), 0);
        chk({tag, ".ffv"}, 32'(ffv_a), 0);
    endtask

    task automatic sweep_a(input string tag, input logic [3:0] tv, input int mode,
                           input int poke_k, input bit prestarted,
                           input bit chain_next, input logic [3:0] next_tv);
        int e, ffi;
        bit ffv;
        e = 0; ffi = 0; ffv = 1'b0;
        mode_a = mode;
        for (int v = 0; v < NV_A; v++) begin
            if (gate_val(mode, v, tbl_a) !== tv[v]) begin
                e++;
                if (!ffv) begin ffi = v; ffv = 1'b1; end
            end
        end
        if (!prestarted) begin
            start_a = 1'b1;
            truth_a = tv;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        chk({tag, ".clr_err"}, 32'(err_a), 0);
        chk({tag, ".clr_pass"}, 32'(pass_a), 0);
        chk({tag, ".clr_ffv"}, 32'(ffv_a), 0);
        for (int k = 0; k < NV_A * SC_A; k++) begin
            if (k == poke_k) begin
                start_a = 1'b1;
                truth_a = ~tv;
            end else begin
                start_a = 1'b0;
            end
            chk($sformatf("%s.dut_in@%0d", tag, k), 32'(dut_in_a), k / SC_A);
            chk($sformatf("%s.busy@%0d", tag, k), 32'(busy_a), 1);
            chk($sformatf("%s.done@%0d", tag, k), 32'(done_a), 0);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        chk({tag, ".done"}, 32'(done_a), 1);
        chk({tag, ".busy_end"}, 32'(busy_a), 0);
        chk({tag, ".err"}, 32'(err_a), e);
        chk({tag, ".ffv"}, 32'(ffv_a), 32'(ffv));
        chk({tag, ".ffi"}, 32'(ffi_a), ffi);
        chk({tag, ".pass"}, 32'(pass_a), (e == 0) ? 1 : 0);
        chk({tag, ".dut_in_end"}, 32'(dut_in_a), NV_A - 1);
        if (chain_next) begin
            start_a = 1'b1;
            truth_a = next_tv;
        end else begin
            @(posedge clk); #1;
            chk({tag, ".done_drop"}, 32'(done_a), 0);
            chk({tag, ".busy_idle"}, 32'(busy_a), 0);
            chk({tag, ".err_hold"}, 32'(err_a), e);
            chk({tag, ".dut_in_hold"}, 32'(dut_in_a), NV_A - 1);
        end
    endtask

    initial begin
        int n;
        logic [3:0] rtv;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset.busy_b", 32'(busy_b), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        sweep_a("or_ok", 4'b1110, 0, -1, 1'b0, 1'b0, 4'b0000);
        sweep_a("and", 4'b1110, 1, -1, 1'b0, 1'b0, 4'b0000);
        sweep_a("stuck0", 4'b1110, 2, -1, 1'b0, 1'b0, 4'b0000);
        sweep_a("stuck1", 4'b0001, 3, -1, 1'b0, 1'b0, 4'b0000);
        sweep_a("restart_ignored", 4'b1110, 0, 3, 1'b0, 1'b0, 4'b0000);

        // Reset mid-sweep while the AND gate is accumulating errors.
        mode_a  = 1;
        start_a = 1'b1;
        truth_a = 4'b1110;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset.err_before", 32'(err_a), 1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_a("after_reset", 4'b1110, 0, -1, 1'b0, 1'b0, 4'b0000);

        // Back-to-back: AND sweep (errors) chained into OR sweep with no idle gap.
        sweep_a("b2b_first", 4'b1110, 1, -1, 1'b0, 1'b1, 4'b1110);
        sweep_a("b2b_second", 4'b1110, 0, -1, 1'b1, 1'b0, 4'b0000);

        for (int r = 0; r < 4; r++) begin
            tbl_a = 4'($urandom);
            rtv   = 4'($urandom);
            sweep_a($sformatf("rand%0d", r), rtv, 4, -1, 1'b0, 1'b0, 4'b0000);
        end

        // Single-cycle settle variant: done four edges after the accepting edge.
        start_b = 1'b1;
        truth_b = 4'b1110;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sc1.latency", 32'(n), 4);
        chk("sc1.pass", 32'(pass_b), 1);
        chk("sc1.err", 32'(err_b), 0);
        chk("sc1.ffv", 32'(ffv_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
